logic_op_arbiter: RTL and testbench

//  Shares one AND/NAND logic unit among NREQ requesters using round-robin arbitration and valid/ready handshakes.

---
 rtl/logic_op_pkg.sv | 23 ++
 rtl/and_nand_unit.sv | 31 +++
 rtl/logic_op_arbiter.sv | 151 +++++++++++++++
 tb/tb_logic_op_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : logic_op_pkg (package)
//  Purpose : Shared definitions for the AND/NAND arbiter slice. Holds the
//            op-select encoding and the arbiter FSM state type.
//  Ports   : n/a (package)
//  Rev     : 1.0  initial release
// ============================================================================
package logic_op_pkg;

   // Per-requester op select encoding
   localparam logic OP_AND  = 1'b0;
   localparam logic OP_NAND = 1'b1;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/and_nand_unit.sv
`default_nettype none
// ============================================================================
//  Module  : and_nand_unit
//  Purpose : Combinational shared logic unit. Produces the bitwise AND or
//            NAND of two operands; the unselected result is forced to zero.
//  Ports   : a_i, b_i     [WIDTH] operands
//            sel_i        op select (OP_AND / OP_NAND)
//            out_and_o    [WIDTH] A&B when sel=OP_AND, else 0
//            out_nand_o   [WIDTH] ~(A&B) when sel=OP_NAND, else 0
//  Rev     : 1.0  initial release
// ============================================================================
module and_nand_unit
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sel_i,
   output logic [WIDTH-1:0] out_and_o,
   output logic [WIDTH-1:0] out_nand_o
);

   logic [WIDTH-1:0] prod;

   assign prod       = a_i & b_i;
   assign out_and_o  = (sel_i == OP_AND)  ? prod  : '0;
   assign out_nand_o = (sel_i == OP_NAND) ? ~prod : '0;

endmodule
`default_nettype wire

// File: rtl/logic_op_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : logic_op_arbiter
//  Purpose : Shares one AND/NAND unit among NREQ requesters using
//            round-robin arbitration with valid/ready handshakes.
//            Sequence per operation: IDLE (accept) -> EXEC -> RESP -> IDLE.
//  Ports   : clk_i          clock, rising edge
//            reset_i        synchronous active-high reset
//            req_valid_i    [NREQ]        requester has an op pending
//            req_sel_i      [NREQ]        op select per requester (0=AND,1=NAND)
//            req_a_i        [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//            req_b_i        [NREQ*WIDTH]  operand B, same packing
//            req_ready_o    [NREQ]        one-hot accept strobe (combinational, IDLE only)
//            rsp_valid_o    [NREQ]        one-hot result-valid to the owner
//            rsp_ready_i    [NREQ]        requester takes its result
//            rsp_and_o      [WIDTH]       AND result (0 for NAND ops)
//            rsp_nand_o     [WIDTH]       NAND result (0 for AND ops)
//            grant_id_o     [clog2(NREQ)] current / last owner
//            busy_o                       high in EXEC and RESP
//  Rev     : 1.0  initial release
// ============================================================================
module logic_op_arbiter
   import logic_op_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [NREQ-1:0]           req_valid_i,
   input  logic [NREQ-1:0]           req_sel_i,
   input  logic [NREQ*WIDTH-1:0]     req_a_i,
   input  logic [NREQ*WIDTH-1:0]     req_b_i,
   output logic [NREQ-1:0]           req_ready_o,
   output logic [NREQ-1:0]           rsp_valid_o,
   input  logic [NREQ-1:0]           rsp_ready_i,
   output logic [WIDTH-1:0]          rsp_and_o,
   output logic [WIDTH-1:0]          rsp_nand_o,
   output logic [$clog2(NREQ)-1:0]   grant_id_o,
   output logic                      busy_o
);

   localparam int IDW = $clog2(NREQ);

   // Round-robin pick: first set bit of v at or after p, wrapping.
   // Scanning from the far end backwards lets the nearest candidate
   // overwrite the result last. MSB of the return value = found.
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [IDW-1:0]  p);
      logic [IDW:0] r;
      int           j;
      r = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = (int'(p) + k) % NREQ;
         if (v[j[IDW-1:0]]) r = {1'b1, j[IDW-1:0]};
      end
      return r;
   endfunction

   state_t            state_q;
   logic [IDW-1:0]    rr_ptr_q;
   logic [IDW-1:0]    owner_q;
   logic [IDW-1:0]    owner_d;
   logic [IDW-1:0]    rr_ptr_d;
   logic [IDW:0]      pick;
   logic              pick_found;
   logic [WIDTH-1:0]  a_q, b_q, a_d, b_d;
   logic              sel_q, sel_d;
   logic [WIDTH-1:0]  and_q, nand_q;
   logic [WIDTH-1:0]  unit_and, unit_nand;
   logic [NREQ-1:0]   rsp_valid_q;
   logic              accept;

   assign pick       = rr_pick(req_valid_i, rr_ptr_q);
   assign pick_found = pick[IDW];
   assign owner_d    = pick[IDW-1:0];

   // Only the winner's operand slice is ever looked at, so garbage on
   // non-granted requesters cannot reach the latches.
   assign a_d   = req_a_i[owner_d*WIDTH +: WIDTH];
   assign b_d   = req_b_i[owner_d*WIDTH +: WIDTH];
   assign sel_d = req_sel_i[owner_d];

   // Reset gates the combinational strobe so no acceptance is signalled
   // in a cycle whose edge will be swallowed by reset.
   assign accept      = (state_q == ST_IDLE) && pick_found && !reset_i;
   assign req_ready_o = accept ? (NREQ'(1) << owner_d) : '0;

   assign rr_ptr_d = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + IDW'(1);

   and_nand_unit #(
      .WIDTH      (WIDTH)
   ) u_unit (
      .a_i        (a_q),
      .b_i        (b_q),
      .sel_i      (sel_q),
      .out_and_o  (unit_and),
      .out_nand_o (unit_nand)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= OP_AND;
         and_q       <= '0;
         nand_q      <= '0;
         rsp_valid_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_found) begin
                  a_q     <= a_d;
                  b_q     <= b_d;
                  sel_q   <= sel_d;
                  owner_q <= owner_d;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               and_q       <= unit_and;
               nand_q      <= unit_nand;
               rsp_valid_q <= NREQ'(1) << owner_q;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               // Only the owner's ready bit completes the handshake.
               if (rsp_ready_i[owner_q]) begin
                  rsp_valid_q <= '0;
                  rr_ptr_q    <= rr_ptr_d;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_and_o   = and_q;
   assign rsp_nand_o  = nand_q;
   assign grant_id_o  = owner_q;
   assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_logic_op_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_logic_op_arbiter
//  Purpose : Self-checking bench for logic_op_arbiter (NREQ=4, WIDTH=4).
//            Table of directed operations, hand-written hold/reset
//            sequences, and random operations against a reference model.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_logic_op_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;

   logic         clk;
   logic         reset;
   logic [3:0]   req_valid;
   logic [3:0]   req_sel;
   logic [15:0]  req_a;
   logic [15:0]  req_b;
   logic [3:0]   req_ready;
   logic [3:0]   rsp_valid;
   logic [3:0]   rsp_ready;
   logic [3:0]   rsp_and;
   logic [3:0]   rsp_nand;
   logic [1:0]   grant_id;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;
   int model_ptr = 0;

   logic_op_arbiter #(
      .NREQ        (NREQ),
      .WIDTH       (WIDTH)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_valid_i (req_valid),
      .req_sel_i   (req_sel),
      .req_a_i     (req_a),
      .req_b_i     (req_b),
      .req_ready_o (req_ready),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_and_o   (rsp_and),
      .rsp_nand_o  (rsp_nand),
      .grant_id_o  (grant_id),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: first valid requester at or after ptr, wrapping; -1 if none.
   function automatic int ref_pick(input logic [3:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (ptr + k) % NREQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [3:0] ref_and(input logic [3:0] a, input logic [3:0] b, input logic s);
      return s ? 4'b0000 : (a & b);
   endfunction

   function automatic logic [3:0] ref_nand(input logic [3:0] a, input logic [3:0] b, input logic s);
      return s ? ~(a & b) : 4'b0000;
   endfunction

   // One full operation, starting in IDLE just after a rising edge.
   task automatic run_op(input logic [3:0] v, input logic [3:0] s,
                         input logic [15:0] a, input logic [15:0] b,
                         input int hold, input int eg,
                         input logic [3:0] eand, input logic [3:0] enand);
      logic [3:0] gmask;
      req_valid = v;
      req_sel   = s;
      req_a     = a;
      req_b     = b;
      rsp_ready = 4'b0000;
      #1;
      if (eg < 0) begin
         chk("idle_req_ready", req_ready, 0);
         tick();
         chk("idle_busy", busy, 0);
         chk("idle_rsp_valid", rsp_valid, 0);
         return;
      end
      gmask = 4'b0001 << eg;
      chk("req_ready", req_ready, gmask);
      chk("busy_in_idle", busy, 0);
      // Scramble operands of non-granted requesters right before the accept edge.
      for (int i = 0; i < NREQ; i++) begin
         if (i != eg) begin
            req_a[i*4 +: 4] = 4'($urandom);
            req_b[i*4 +: 4] = 4'($urandom);
         end
      end
      tick();
      chk("grant_id", grant_id, eg);
      chk("busy_exec", busy, 1);
      chk("req_ready_exec", req_ready, 0);
      chk("rsp_valid_exec", rsp_valid, 0);
      // Inputs after acceptance must not influence the in-flight op.
      req_valid = 4'($urandom);
      req_sel   = 4'($urandom);
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      tick();
      chk("rsp_valid", rsp_valid, gmask);
      chk("rsp_and", rsp_and, eand);
      chk("rsp_nand", rsp_nand, enand);
      for (int h = 0; h < hold; h++) begin
         rsp_ready = 4'($urandom) & ~gmask;
         req_valid = 4'($urandom);
         tick();
         chk("hold_rsp_valid", rsp_valid, gmask);
         chk("hold_and", rsp_and, eand);
         chk("hold_nand", rsp_nand, enand);
         chk("hold_req_ready", req_ready, 0);
         chk("hold_busy", busy, 1);
      end
      rsp_ready = 4'($urandom) | gmask;
      tick();
      chk("done_rsp_valid", rsp_valid, 0);
      chk("done_busy", busy, 0);
      rsp_ready = 4'b0000;
      model_ptr = (eg + 1) % NREQ;
   endtask

   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  sel;
      logic [15:0] a;
      logic [15:0] b;
      int          grant;
      logic [3:0]  exp_and;
      logic [3:0]  exp_nand;
   } vec_t;

   vec_t tbl [6];

   initial begin
      // Directed vectors applied back-to-back after reset (rr_ptr starts at 0).
      tbl[0] = '{4'b0001, 4'b0000, 16'h000C, 16'h000A, 0, 4'b1000, 4'b0000};
      tbl[1] = '{4'b0100, 4'b0100, 16'h0C00, 16'h0A00, 2, 4'b0000, 4'b0111};
      tbl[2] = '{4'b1111, 4'b0000, 16'hF000, 16'h6000, 3, 4'b0110, 4'b0000};
      tbl[3] = '{4'b1010, 4'b0010, 16'h0050, 16'h0070, 1, 4'b0000, 4'b1010};
      tbl[4] = '{4'b0011, 4'b0001, 16'h00FF, 16'h00FF, 0, 4'b0000, 4'b0000};
      tbl[5] = '{4'b1001, 4'b0000, 16'h9000, 16'hC000, 3, 4'b1000, 4'b0000};

      reset     = 1'b1;
      req_valid = 4'b0000;
      req_sel   = 4'b0000;
      req_a     = 16'h0000;
      req_b     = 16'h0000;
      rsp_ready = 4'b0000;

      // Reset held two cycles, then idle with no requests.
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_and", rsp_and, 0);
      chk("rst_nand", rsp_nand, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_busy", busy, 0);

      for (int i = 0; i < 6; i++)
         run_op(tbl[i].valid, tbl[i].sel, tbl[i].a, tbl[i].b, 0,
                tbl[i].grant, tbl[i].exp_and, tbl[i].exp_nand);

      // All requesters valid with ready held: pointer is 0, grants rotate 0,1,2,3,0.
      for (int i = 0; i < 5; i++)
         run_op(4'b1111, 4'b0000, 16'hFFFF, 16'h5A5A, 0, i % NREQ,
                4'(16'h5A5A >> ((i % NREQ) * 4)), 4'b0000);

      // Owner stalls its ready for 5 cycles; results held, no new acceptance.
      run_op(4'b0100, 4'b0100, 16'h0300, 16'h0600, 5, 2, 4'b0000, 4'b1101);

      // Reset during EXEC: in-flight op dropped, pointer back to 0.
      run_op(4'b0010, 4'b0000, 16'h0000, 16'h0000, 0, 1, 4'b0000, 4'b0000);
      req_valid = 4'b1111;
      tick();
      chk("rexec_busy", busy, 1);
      chk("rexec_grant", grant_id, 2);
      reset = 1'b1;
      #1;
      chk("rexec_ready_in_reset", req_ready, 0);
      tick();
      reset = 1'b0;
      req_valid = 4'b0000;
      tick();
      chk("rexec_rsp_valid", rsp_valid, 0);
      chk("rexec_busy_after", busy, 0);
      chk("rexec_grant_after", grant_id, 0);
      model_ptr = 0;
      run_op(4'b1111, 4'b1000, 16'h0000, 16'h0000, 0, 0, 4'b0000, 4'b0000);

      // Random operations against the reference model.
      for (int n = 0; n < 60; n++) begin
         logic [3:0]  v, s;
         logic [15:0] a, b;
         int          g;
         logic [3:0]  ea, en;
         v = 4'($urandom);
         s = 4'($urandom);
         a = 16'($urandom);
         b = 16'($urandom);
         g = ref_pick(v, model_ptr);
         ea = 4'b0000;
         en = 4'b0000;
         if (g >= 0) begin
            ea = ref_and(a[g*4 +: 4], b[g*4 +: 4], s[g]);
            en = ref_nand(a[g*4 +: 4], b[g*4 +: 4], s[g]);
         end
         run_op(v, s, a, b, $urandom_range(0, 3), g, ea, en);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
